// File: rtl/instr_boot_loader_if.sv
// instr_boot_loader_if: byte-stream input, CPU load drive and status signals of the boot loader
interface instr_boot_loader_if #(parameter int CNT_W = 6);
  logic start;
  logic [7:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic cpu_reset;
  logic LoadInstructions;
  logic [31:0] Instruction;
  logic busy;
  logic done;
  logic error;
  logic [CNT_W-1:0] words_loaded;
  modport master (
    output start, byte_in, byte_valid,
    input byte_ready, cpu_reset, LoadInstructions, Instruction, busy, done, error, words_loaded
  );
  modport slave (
    input start, byte_in, byte_valid,
    output byte_ready, cpu_reset, LoadInstructions, Instruction, busy, done, error, words_loaded
  );
endinterface

// File: rtl/instr_boot_loader.sv
// instr_boot_loader: assembles a header+program byte stream into words and bursts them into the CPU load path
module instr_boot_loader #(
  parameter int MAX_WORDS = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic Reset,
  instr_boot_loader_if.slave bus
);
  localparam int AW = $clog2(MAX_WORDS);
  typedef enum logic [2:0] {IDLE, HDR, RECV, PRERST, BURST, POSTRST, RUN, ERR} state_t;
  state_t state, nextState;
  logic [31:0] mem [MAX_WORDS];
  logic [CNT_W-1:0] nWords, wrCnt, rdCnt, nextRd;
  logic [1:0] byteCnt;
  logic [23:0] partial;
  logic take, lastByte, lastRd;
  assign bus.byte_ready = state == HDR || state == RECV;
  assign bus.busy = state inside {HDR, RECV, PRERST, BURST, POSTRST};
  assign bus.done = state == RUN;
  assign bus.error = state == ERR;
  always_comb begin
    take = bus.byte_ready && bus.byte_valid;
    lastByte = take && byteCnt == 2'd3;
    lastRd = rdCnt == nWords - 1'b1;
    nextRd = state == BURST ? rdCnt + 1'b1 : '0;
    nextState = state;
    case (state)
      IDLE: nextState = bus.start ? HDR : IDLE;
      HDR: if (take) nextState = (bus.byte_in == 8'd0 || bus.byte_in > 8'(MAX_WORDS)) ? ERR : RECV;
      RECV: if (lastByte && wrCnt == nWords - 1'b1) nextState = PRERST;
      PRERST: nextState = BURST;
      BURST: nextState = lastRd ? POSTRST : BURST;
      POSTRST: nextState = RUN;
      RUN, ERR: nextState = bus.start ? HDR : state;
      default: nextState = IDLE;
    endcase
  end
  // CPU-facing outputs are registered from nextState so they line up with the state they belong to
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      nWords <= '0;
      wrCnt <= '0;
      rdCnt <= '0;
      byteCnt <= '0;
      partial <= '0;
      bus.cpu_reset <= 1'b1;
      bus.LoadInstructions <= 1'b0;
      bus.Instruction <= '0;
      bus.words_loaded <= '0;
    end else begin
      state <= nextState;
      bus.cpu_reset <= nextState != BURST && nextState != RUN;
      bus.LoadInstructions <= nextState == BURST;
      bus.Instruction <= nextState == BURST ? mem[nextRd[AW-1:0]] : '0;
      if (nextState == BURST) rdCnt <= nextRd;
      if (state == PRERST) bus.words_loaded <= '0;
      if (state == BURST) bus.words_loaded <= rdCnt + 1'b1;
      if (state == HDR && take) begin
        nWords <= bus.byte_in[CNT_W-1:0];
        wrCnt <= '0;
        byteCnt <= '0;
      end
      if (state == RECV && take) begin
        byteCnt <= byteCnt + 1'b1;
        partial <= {partial[15:0], bus.byte_in};
        if (lastByte && nextState != PRERST) wrCnt <= wrCnt + 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (state == RECV && lastByte) mem[wrCnt[AW-1:0]] <= {partial, bus.byte_in};
endmodule
